mult_issue_scheduler: RTL and testbench
=======================================

Name: mult_issue_scheduler

Overview:
- Shares a pool of pipelined multiply functional units between the two issue ways of the 2-way superscalar core.
- Each cycle: grants up to two in-order multiply issue requests to free units and tracks per-unit occupancy (IDLE/BUSY/WAIT_CDB).
- Holds each finished unit until the CDB arbiter accepts its result, then frees the unit.
- Sits between the reservation-station select logic and the fu_mult instances; a squash clears all units.

Parameters:
NUM_MULT, 2, number of multiply units in the pool (power of 2, ≥2)
TAG_W, 5, ROB tag width carried per unit
TIMEOUT, 15, max cycles a unit may stay BUSY before err_timeout is flagged

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
squash  in  1  pipeline flush; all units return to IDLE
req_valid  in  2  issue request per way; bit 0 is the older instruction
req_tag  in  2*TAG_W  ROB tag per request
grant  out  2  request accepted this cycle (combinational)
grant_unit  out  2*log2(NUM_MULT)  unit index assigned to each granted request
unit_start  out  NUM_MULT  one-hot-per-unit launch pulse to the fu_mult "valid" input (combinational, equals the grant)
unit_done  in  NUM_MULT  unit result valid (fu_result_valid)
cdb_req  out  NUM_MULT  unit holds a result awaiting the CDB (registered state decode)
cdb_grant  in  NUM_MULT  CDB accepted the unit's result
unit_tag  out  NUM_MULT*TAG_W  ROB tag held by each unit
free_count  out  log2(NUM_MULT)+1  number of IDLE units (registered state decode)
err_timeout  out  1  sticky; some unit exceeded TIMEOUT in BUSY

Behaviour:
- Reset (sync, active-high) or squash:
  - All units go to IDLE and unit_tag is cleared to 0.
  - Busy counters are cleared.
  - grant, unit_start and cdb_req are 0 in the squash cycle; free_count is NUM_MULT on the following cycle.
  - err_timeout is cleared by reset only; squash does not clear it.
- Per-unit FSM:
  - IDLE → BUSY on unit_start; the unit latches its req_tag.
  - BUSY → WAIT_CDB when unit_done=1.
  - WAIT_CDB → IDLE when cdb_grant=1.
  - cdb_grant for a unit not in WAIT_CDB is ignored.
  - unit_done outside BUSY is ignored.
- Arbitration (combinational, from registered state):
  - Free set = units in IDLE at the start of the cycle.
  - A unit leaving WAIT_CDB this cycle is not grantable until the next cycle.
  - req0 gets the lowest-index free unit; req1 gets the next-lowest free unit.
  - In-order rule: grant[1] requires grant[0], or req_valid[0]=0. If req0 is denied, req1 is denied even when a unit is free.
  - With req_valid[0]=0 and req_valid[1]=1, req1 takes the lowest free unit.
  - No free unit → grant=0. Only one free unit and both requests valid → grant=2'b01.
  - Index outputs for ungranted requests are 0.
- Latency: grant at cycle N; unit is BUSY at N+1; cdb_req asserts the cycle after unit_done.
- Busy counter: per unit, increments each BUSY cycle and saturates at TIMEOUT+1. Reaching TIMEOUT+1 sets err_timeout. The counter clears on leaving BUSY.
- Simultaneous unit_done and squash: squash wins.
- A unit can be in WAIT_CDB indefinitely; it stays allocated (back-pressure) until cdb_grant arrives.

Test Plan:
- Reset, then req_valid=2'b11 with tags 3 and 7 → grant=2'b11, grant_unit={1,0}, unit_start=2'b11; next cycle unit_tag={7,3}, free_count=0.
- Both units BUSY, req_valid=2'b01 → grant=0. Then unit_done[1]=1, one cycle later cdb_grant[1]=1 → cdb_req[1] high one cycle; next cycle req0 is granted unit 1.
- One free unit, req_valid=2'b11 → grant=2'b01. With req_valid=2'b10 → grant=2'b10, grant_unit[1]=free index.
- Unit 0 in WAIT_CDB with cdb_grant withheld for 20 cycles → cdb_req[0] stays 1, unit 0 is never granted, err_timeout stays 0.
- Unit BUSY with no unit_done for 16 cycles → err_timeout=1; it stays 1 across a later squash and clears only on reset.
- Squash while units are BUSY and WAIT_CDB, with req_valid=2'b11 in the same cycle → grant=0; next cycle free_count=2, cdb_req=0, and late unit_done pulses are ignored.

Source files
------------

// File: rtl/mult_issue_scheduler.sv
// Multiply-unit issue scheduler: grants up to two in-order issue requests
// to free pipelined multiply units and tracks each unit through
// IDLE -> BUSY -> WAIT_CDB -> IDLE, holding results until the CDB accepts them.
module mult_issue_scheduler #(
    parameter int NUM_MULT = 2,
    parameter int TAG_W    = 5,
    parameter int TIMEOUT  = 15
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      squash,
    input  logic [1:0]                req_valid,
    input  logic [2*TAG_W-1:0]        req_tag,
    output logic [1:0]                grant,
    output logic [2*$clog2(NUM_MULT)-1:0] grant_unit,
    output logic [NUM_MULT-1:0]       unit_start,
    input  logic [NUM_MULT-1:0]       unit_done,
    output logic [NUM_MULT-1:0]       cdb_req,
    input  logic [NUM_MULT-1:0]       cdb_grant,
    output logic [NUM_MULT*TAG_W-1:0] unit_tag,
    output logic [$clog2(NUM_MULT):0] free_count,
    output logic                      err_timeout
);

    localparam int IDX_W = $clog2(NUM_MULT);
    localparam int CNT_W = $clog2(TIMEOUT + 2);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY     = 2'd1,
        WAIT_CDB = 2'd2
    } unit_state_t;

    unit_state_t      state      [NUM_MULT];
    unit_state_t      state_next [NUM_MULT];
    logic [CNT_W-1:0] busy_cnt   [NUM_MULT];
    logic [TAG_W-1:0] tag_q      [NUM_MULT];
    logic [TAG_W-1:0] start_tag  [NUM_MULT];

    logic             kill;
    logic [IDX_W-1:0] first_idx;
    logic [IDX_W-1:0] second_idx;
    logic             first_found;
    logic             second_found;
    logic             grant0;
    logic             grant1;
    logic [IDX_W-1:0] unit1_idx;

    assign kill = reset | squash;

    // Arbitration: pick the two lowest-index units that were IDLE at the start of the cycle.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        first_idx    = '0;
        second_idx   = '0;
        first_found  = 1'b0;
        second_found = 1'b0;
        for (int u = 0; u < NUM_MULT; u++) begin
            if (state[u] == IDLE) begin
                if (!first_found) begin
                    first_idx   = IDX_W'(u);
                    first_found = 1'b1;
                end else if (!second_found) begin
                    second_idx   = IDX_W'(u);
                    second_found = 1'b1;
                end
            end
        end

        // Older request first; the younger one may only bypass an absent older request.
        grant0 = !kill && req_valid[0] && first_found;
        if (req_valid[0]) begin
            grant1    = !kill && req_valid[1] && grant0 && second_found;
            unit1_idx = second_idx;
        end else begin
            grant1    = !kill && req_valid[1] && first_found;
            unit1_idx = first_idx;
        end

        grant      = {grant1, grant0};
        grant_unit = {grant1 ? unit1_idx : IDX_W'(0), grant0 ? first_idx : IDX_W'(0)};

        for (int u = 0; u < NUM_MULT; u++) begin
            unit_start[u] = 1'b0;
            start_tag[u]  = '0;
            if (grant0 && first_idx == IDX_W'(u)) begin
                unit_start[u] = 1'b1;
                start_tag[u]  = req_tag[TAG_W-1:0];
            end else if (grant1 && unit1_idx == IDX_W'(u)) begin
                unit_start[u] = 1'b1;
                start_tag[u]  = req_tag[2*TAG_W-1:TAG_W];
            end
        end
    end

    // Per-unit next-state logic; squash overrides every other event.
    always_comb begin
        for (int u = 0; u < NUM_MULT; u++) begin
            state_next[u] = state[u];
            case (state[u])
                IDLE:     if (unit_start[u]) state_next[u] = BUSY;
                BUSY:     if (unit_done[u])  state_next[u] = WAIT_CDB;
                WAIT_CDB: if (cdb_grant[u])  state_next[u] = IDLE;
                default:                     state_next[u] = IDLE;
            endcase
            if (squash) state_next[u] = IDLE;
        end
    end

    // State, tag and busy-counter registers for every unit.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clock) begin
        for (int u = 0; u < NUM_MULT; u++) begin
            if (reset) begin
                state[u]    <= IDLE;
                tag_q[u]    <= '0;
                busy_cnt[u] <= '0;
            end else begin
                state[u] <= state_next[u];
                if (squash)             tag_q[u] <= '0;
                else if (unit_start[u]) tag_q[u] <= start_tag[u];
                if (state[u] == BUSY && state_next[u] == BUSY) begin
                    if (busy_cnt[u] != CNT_SAT) busy_cnt[u] <= busy_cnt[u] + CNT_W'(1);
                end else begin
                    busy_cnt[u] <= '0;
                end
            end
        end
    end

    // Sticky timeout flag: set when any busy counter saturates, cleared by reset only.
    always_ff @(posedge clock) begin
        if (reset) begin
            err_timeout <= 1'b0;
        end else begin
            for (int u = 0; u < NUM_MULT; u++) begin
                if (!squash && state[u] == BUSY && state_next[u] == BUSY &&
                    busy_cnt[u] == CNT_SAT - CNT_W'(1)) begin
                    err_timeout <= 1'b1;
                end
            end
        end
    end

    // Registered-state decodes: CDB requests, free count and flattened tags.
    always_comb begin
        free_count = '0;
        for (int u = 0; u < NUM_MULT; u++) begin
            cdb_req[u]                    = !kill && state[u] == WAIT_CDB;
            unit_tag[u*TAG_W +: TAG_W]    = tag_q[u];
            if (state[u] == IDLE) free_count = free_count + (IDX_W+1)'(1);
        end
    end

endmodule

// File: tb/tb_mult_issue_scheduler.sv
// Directed bench for mult_issue_scheduler with NUM_MULT=2, TAG_W=5, TIMEOUT=15.
module tb_mult_issue_scheduler;

    logic       clock = 1'b0;
    logic       reset;
    logic       squash;
    logic [1:0] req_valid;
    logic [9:0] req_tag;
    logic [1:0] grant;
    logic [1:0] grant_unit;
    logic [1:0] unit_start;
    logic [1:0] unit_done;
    logic [1:0] cdb_req;
    logic [1:0] cdb_grant;
    logic [9:0] unit_tag;
    logic [1:0] free_count;
    logic       err_timeout;

    int n_checks = 0;
    int n_errors = 0;

    mult_issue_scheduler #(.NUM_MULT(2), .TAG_W(5), .TIMEOUT(15)) dut (
        .clock      (clock),
        .reset      (reset),
        .squash     (squash),
        .req_valid  (req_valid),
        .req_tag    (req_tag),
        .grant      (grant),
        .grant_unit (grant_unit),
        .unit_start (unit_start),
        .unit_done  (unit_done),
        .cdb_req    (cdb_req),
        .cdb_grant  (cdb_grant),
        .unit_tag   (unit_tag),
        .free_count (free_count),
        .err_timeout(err_timeout)
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", name, observed, expected);
        end
    endtask

    // Apply inputs just after a rising edge, then settle before checking.
    task automatic drive(input logic [1:0] rv, input logic [4:0] t0, input logic [4:0] t1,
                         input logic [1:0] ud, input logic [1:0] cg, input logic sq);
        req_valid = rv;
        req_tag   = {t1, t0};
        unit_done = ud;
        cdb_grant = cg;
        squash    = sq;
        #1;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        drive(2'b00, 5'd0, 5'd0, 2'b00, 2'b00, 1'b0);
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        drive(2'b00, 5'd0, 5'd0, 2'b00, 2'b00, 1'b0);
        check("rst_free", free_count, 2);
        check("rst_cdb", cdb_req, 0);
        check("rst_grant", grant, 0);
        check("rst_err", err_timeout, 0);
        check("rst_tag", unit_tag, 0);
        tick();

        // Dual grant: req0->unit0, req1->unit1
        drive(2'b11, 5'd3, 5'd7, 2'b00, 2'b00, 1'b0);
        check("dual_grant", grant, 2'b11);
        check("dual_unit", grant_unit, 2'b10);
        check("dual_start", unit_start, 2'b11);
        tick();

        // Both busy: no grant
        drive(2'b01, 5'd9, 5'd0, 2'b00, 2'b00, 1'b0);
        check("busy_tags", unit_tag, {5'd7, 5'd3});
        check("busy_free", free_count, 0);
        check("busy_grant", grant, 0);
        check("busy_start", unit_start, 0);
        tick();

        // Unit 1 finishes
        drive(2'b00, 5'd0, 5'd0, 2'b10, 2'b00, 1'b0);
        check("done_cdb_pre", cdb_req, 0);
        tick();

        // Unit 1 leaves WAIT_CDB this cycle: still not grantable
        drive(2'b01, 5'd9, 5'd0, 2'b00, 2'b10, 1'b0);
        check("wait_cdb", cdb_req, 2'b10);
        check("leaving_grant", grant, 0);
        tick();

        // One free unit, both requests: only req0 granted, to unit 1
        drive(2'b11, 5'd4, 5'd5, 2'b00, 2'b00, 1'b0);
        check("freed_cdb", cdb_req, 0);
        check("one_free", free_count, 1);
        check("one_grant", grant, 2'b01);
        check("one_unit", grant_unit, 2'b01);
        check("one_start", unit_start, 2'b10);
        tick();

        // Both units finish together
        drive(2'b00, 5'd0, 5'd0, 2'b11, 2'b00, 1'b0);
        check("reissue_tag", unit_tag, {5'd4, 5'd3});
        tick();

        drive(2'b00, 5'd0, 5'd0, 2'b00, 2'b10, 1'b0);
        check("both_wait", cdb_req, 2'b11);
        check("both_wait_free", free_count, 0);
        tick();

        // Only the younger request valid: takes lowest free unit (1)
        drive(2'b10, 5'd0, 5'd12, 2'b00, 2'b00, 1'b0);
        check("young_grant", grant, 2'b10);
        check("young_unit", grant_unit, 2'b10);
        check("young_start", unit_start, 2'b10);
        tick();

        drive(2'b00, 5'd0, 5'd0, 2'b10, 2'b00, 1'b0);
        check("young_tag", unit_tag, {5'd12, 5'd3});
        tick();

        // Back-pressure: both in WAIT_CDB for 20 cycles
        for (int i = 0; i < 20; i++) begin
            drive(2'b11, 5'd1, 5'd2, 2'b00, 2'b00, 1'b0);
            check("bp_cdb", cdb_req, 2'b11);
            check("bp_grant", grant, 0);
            check("bp_err", err_timeout, 0);
            tick();
        end

        // Release unit 0, then unit 1 while req0 takes unit 0
        drive(2'b00, 5'd0, 5'd0, 2'b00, 2'b01, 1'b0);
        check("rel_cdb", cdb_req, 2'b11);
        tick();

        drive(2'b01, 5'd20, 5'd0, 2'b00, 2'b10, 1'b0);
        check("rel_grant", grant, 2'b01);
        check("rel_unit", grant_unit, 2'b00);
        check("rel_start", unit_start, 2'b01);
        check("rel_cdb1", cdb_req, 2'b10);
        tick();

        // Timeout: unit 0 BUSY, no done; stray cdb_grant ignored
        for (int i = 0; i < 15; i++) begin
            drive(2'b00, 5'd0, 5'd0, 2'b00, 2'b01, 1'b0);
            check("to_err_low", err_timeout, 0);
            check("to_free", free_count, 1);
            tick();
        end
        drive(2'b00, 5'd0, 5'd0, 2'b00, 2'b00, 1'b0);
        check("to_err_edge", err_timeout, 0);
        tick();
        drive(2'b00, 5'd0, 5'd0, 2'b00, 2'b00, 1'b0);
        check("to_err_set", err_timeout, 1);
        check("to_tag", unit_tag, {5'd12, 5'd20});

        // Unit 1 to BUSY then WAIT_CDB
        drive(2'b01, 5'd6, 5'd0, 2'b00, 2'b00, 1'b0);
        check("sq_pre_unit", grant_unit, 2'b01);
        tick();
        drive(2'b00, 5'd0, 5'd0, 2'b10, 2'b00, 1'b0);
        tick();

        // Squash with requests and a done pulse in the same cycle
        drive(2'b11, 5'd8, 5'd9, 2'b01, 2'b00, 1'b1);
        check("sq_grant", grant, 0);
        check("sq_start", unit_start, 0);
        check("sq_cdb", cdb_req, 0);
        tick();

        drive(2'b00, 5'd0, 5'd0, 2'b11, 2'b00, 1'b0);
        check("post_sq_free", free_count, 2);
        check("post_sq_cdb", cdb_req, 0);
        check("post_sq_tag", unit_tag, 0);
        check("post_sq_err", err_timeout, 1);
        tick();

        drive(2'b00, 5'd0, 5'd0, 2'b00, 2'b00, 1'b0);
        check("late_done_free", free_count, 2);
        check("late_done_cdb", cdb_req, 0);
        tick();

        // Only reset clears the sticky error
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(2'b00, 5'd0, 5'd0, 2'b00, 2'b00, 1'b0);
        check("rst2_err", err_timeout, 0);
        check("rst2_free", free_count, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
